// File: rtl/mul_pkg.sv
// mul_pkg: values shared by the multiply/accumulate slice.
//   PROD_W  - width of one product from the 4x4 multiplier
//   state_t - control state encoding (2'd3 is unreachable and decodes as idle)
//   clog2   - ceil(log2(n)) for sizing counters at elaboration time
package mul_pkg;

    localparam int unsigned PROD_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StAcc  = 2'd1;
    localparam state_t StDone = 2'd2;

    // ceil(log2(n)); clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_dot_acc_if.sv
// mul_dot_acc_if: product input stream plus result output stream.
//   in_valid/in_prod/in_ready        - one product per handshake
//   out_valid/out_sum/out_ovf/out_ready - finished dot product
// master: the side that supplies products and consumes results.
// slave:  the accumulator.
interface mul_dot_acc_if #(
    parameter int unsigned ACC_W = 12
);
    import mul_pkg::*;

    logic              in_valid;
    logic [PROD_W-1:0] in_prod;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_prod,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf,
        input  out_ready
    );

endinterface

// File: rtl/mul_dot_acc_ctrl.sv
// mul_dot_acc_ctrl: state machine and term counter for the dot-product accumulator.
//   clk, rst       - clock, synchronous active-high reset
//   start, clear   - begin a dot product (idle only) / abort to idle
//   in_valid       - product offered this cycle
//   out_ready      - downstream takes the result
//   in_ready       - accepting products (decoded from state)
//   out_valid      - result available (decoded from state)
//   busy           - in accumulate or done
//   acc_clr        - datapath must zero the accumulator and overflow flag
//   acc_en         - datapath must add the offered product
module mul_dot_acc_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned N_TERMS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic acc_clr,
    output logic acc_en
);

    localparam int unsigned CntW = clog2(N_TERMS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_acc;
    logic            in_done;
    logic            in_idle;

    assign in_acc  = (state_q == StAcc);
    assign in_done = (state_q == StDone);
    // Unreachable encoding behaves as idle.
    assign in_idle = !(in_acc || in_done);

    always_comb begin
        in_ready  = in_acc;
        out_valid = in_done;
        busy      = in_acc || in_done;
        acc_clr   = clear || (in_idle && start);
        acc_en    = in_acc && in_valid;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StAcc: begin
                    if (in_valid) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    // start during the completing handshake is dropped here.
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = StAcc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_dot_acc.sv
// mul_dot_acc: sums N_TERMS unsigned 8-bit products into an ACC_W-bit result.
//   clk, rst - clock, synchronous active-high reset
//   start    - one-cycle pulse, starts a dot product when idle
//   clear    - synchronous abort; accumulator and overflow flag zeroed
//   busy     - accumulating or holding a result
//   bus      - product input / result output handshakes (slave side)
// out_sum is the accumulator itself, so it keeps the last result after the
// output handshake until the next start or clear.
module mul_dot_acc
    import mul_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           clear,
    output logic           busy,
    mul_dot_acc_if.slave   bus
);

    logic             acc_clr;
    logic             acc_en;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_ext;

    mul_dot_acc_ctrl #(
        .N_TERMS (N_TERMS)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .busy      (busy),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en)
    );

    // One extra bit on the adder captures the carry out for the sticky flag.
    always_comb begin
        prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
        sum_ext  = {1'b0, acc_q} + prod_ext;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (acc_en) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | sum_ext[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_sum = acc_q;
    assign bus.out_ovf = ovf_q;

endmodule

// File: tb/tb_mul_dot_acc.sv
// Scoreboard bench: three builds (default, ACC_W=9 wrap, N_TERMS=1).
// Stimulus pushes expected results; per-build monitors pop on each output handshake.
module tb_mul_dot_acc;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] clear;
    logic [2:0] busy;
    logic [2:0] iv;
    logic [2:0] orr;
    logic [7:0] ip [3];

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int n_checks;
    int n_fail;

    mul_dot_acc_if #(.ACC_W(12)) if_a ();
    mul_dot_acc_if #(.ACC_W(9))  if_b ();
    mul_dot_acc_if #(.ACC_W(12)) if_c ();

    assign if_a.in_valid  = iv[0];
    assign if_a.in_prod   = ip[0];
    assign if_a.out_ready = orr[0];
    assign if_b.in_valid  = iv[1];
    assign if_b.in_prod   = ip[1];
    assign if_b.out_ready = orr[1];
    assign if_c.in_valid  = iv[2];
    assign if_c.in_prod   = ip[2];
    assign if_c.out_ready = orr[2];

    mul_dot_acc #(.N_TERMS(4), .ACC_W(12)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start[0]),
        .clear (clear[0]),
        .busy  (busy[0]),
        .bus   (if_a)
    );

    mul_dot_acc #(.N_TERMS(4), .ACC_W(9)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start[1]),
        .clear (clear[1]),
        .busy  (busy[1]),
        .bus   (if_b)
    );

    mul_dot_acc #(.N_TERMS(1), .ACC_W(12)) dut_c (
        .clk   (clk),
        .rst   (rst),
        .start (start[2]),
        .clear (clear[2]),
        .busy  (busy[2]),
        .bus   (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int p);
        iv[k] = 1'b1;
        ip[k] = 8'(p);
        cyc();
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        cyc();
        start[k] = 1'b0;
    endtask

    // Monitors: sample on the falling edge, pop on valid & ready.
    always @(negedge clk) begin
        exp_t e;
        if (if_a.out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", 32'(if_a.out_valid), 0);
            end else if (orr[0]) begin
                e = qa.pop_front();
                check("a_sum", 32'(if_a.out_sum), e.sum);
                check("a_ovf", 32'(if_a.out_ovf), e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_b.out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", 32'(if_b.out_valid), 0);
            end else if (orr[1]) begin
                e = qb.pop_front();
                check("b_sum", 32'(if_b.out_sum), e.sum);
                check("b_ovf", 32'(if_b.out_ovf), e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_c.out_valid === 1'b1) begin
            if (qc.size() == 0) begin
                check("c_unexpected_valid", 32'(if_c.out_valid), 0);
            end else if (orr[2]) begin
                e = qc.pop_front();
                check("c_sum", 32'(if_c.out_sum), e.sum);
                check("c_ovf", 32'(if_c.out_ovf), e.ovf);
            end
        end
    end

    initial begin
        int running;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = '0;
        clear = '0;
        iv    = '0;
        orr   = '1;
        for (int k = 0; k < 3; k++) ip[k] = '0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(if_a.in_ready), 0);
        check("rst_out_valid", 32'(if_a.out_valid), 0);
        check("rst_out_sum", 32'(if_a.out_sum), 0);
        check("rst_out_ovf", 32'(if_a.out_ovf), 0);
        check("rst_busy", 32'(busy), 0);

        // 225 x4, back to back
        pulse_start(0);
        check("t1_in_ready", 32'(if_a.in_ready), 1);
        qa.push_back('{sum: 900, ovf: 0});
        for (int i = 0; i < 4; i++) begin
            send(0, 225);
            if (i < 3) check("t1_no_early_valid", 32'(if_a.out_valid), 0);
        end
        iv[0] = 1'b0;
        check("t1_latency_valid", 32'(if_a.out_valid), 1);
        check("t1_busy_done", 32'(busy[0]), 1);
        cyc();
        check("t1_valid_drop", 32'(if_a.out_valid), 0);
        check("t1_busy_idle", 32'(busy[0]), 0);
        check("t1_sum_kept", 32'(if_a.out_sum), 900);

        // 1,2,3,4 with two-cycle gaps
        pulse_start(0);
        qa.push_back('{sum: 10, ovf: 0});
        running = 0;
        for (int i = 0; i < 4; i++) begin
            send(0, i + 1);
            iv[0] = 1'b0;
            running += i + 1;
            if (i < 3) begin
                repeat (2) begin
                    check("t2_gap_ready", 32'(if_a.in_ready), 1);
                    check("t2_gap_acc", 32'(if_a.out_sum), 32'(running));
                    cyc();
                end
            end
        end
        check("t2_valid", 32'(if_a.out_valid), 1);
        cyc();

        // Backpressure in done; stray input ignored
        orr[0] = 1'b0;
        pulse_start(0);
        qa.push_back('{sum: 140, ovf: 0});
        send(0, 20);
        send(0, 30);
        send(0, 40);
        send(0, 50);
        iv[0] = 1'b0;
        repeat (5) begin
            check("t3_hold_valid", 32'(if_a.out_valid), 1);
            check("t3_hold_sum", 32'(if_a.out_sum), 140);
            check("t3_hold_in_ready", 32'(if_a.in_ready), 0);
            send(0, 99);
        end
        iv[0] = 1'b0;
        orr[0] = 1'b1;
        cyc();
        check("t3_valid_drop", 32'(if_a.out_valid), 0);
        check("t3_sum_kept", 32'(if_a.out_sum), 140);

        // start while accumulating, and start on the completing handshake
        pulse_start(0);
        qa.push_back('{sum: 30, ovf: 0});
        send(0, 6);
        send(0, 7);
        iv[0] = 1'b0;
        pulse_start(0);
        check("t4_no_restart", 32'(if_a.out_sum), 13);
        send(0, 8);
        send(0, 9);
        iv[0] = 1'b0;
        check("t4_valid", 32'(if_a.out_valid), 1);
        pulse_start(0);
        check("t4_start_on_done_ignored", 32'(busy[0]), 0);

        // clear (with start) mid-run, then rst mid-run, then fresh run
        pulse_start(0);
        send(0, 10);
        send(0, 20);
        iv[0]    = 1'b0;
        clear[0] = 1'b1;
        start[0] = 1'b1;
        cyc();
        clear[0] = 1'b0;
        start[0] = 1'b0;
        check("t5_clear_busy", 32'(busy[0]), 0);
        check("t5_clear_sum", 32'(if_a.out_sum), 0);
        check("t5_clear_in_ready", 32'(if_a.in_ready), 0);
        repeat (3) cyc();
        pulse_start(0);
        send(0, 5);
        iv[0] = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t5_rst_busy", 32'(busy[0]), 0);
        check("t5_rst_sum", 32'(if_a.out_sum), 0);
        pulse_start(0);
        qa.push_back('{sum: 40, ovf: 0});
        repeat (4) send(0, 10);
        iv[0] = 1'b0;
        check("t5_valid", 32'(if_a.out_valid), 1);
        cyc();

        // ACC_W=9: 900 wraps to 388, overflow flagged and sticky until start
        pulse_start(1);
        qb.push_back('{sum: 388, ovf: 1});
        repeat (4) send(1, 225);
        iv[1] = 1'b0;
        check("t6_valid", 32'(if_b.out_valid), 1);
        cyc();
        check("t6_ovf_sticky", 32'(if_b.out_ovf), 1);
        check("t6_sum_kept", 32'(if_b.out_sum), 388);
        pulse_start(1);
        check("t6_ovf_cleared", 32'(if_b.out_ovf), 0);
        check("t6_acc_cleared", 32'(if_b.out_sum), 0);

        // N_TERMS=1: single handshake completes
        pulse_start(2);
        qc.push_back('{sum: 200, ovf: 0});
        send(2, 200);
        iv[2] = 1'b0;
        check("t7_valid", 32'(if_c.out_valid), 1);
        check("t7_sum", 32'(if_c.out_sum), 200);
        cyc();
        check("t7_valid_drop", 32'(if_c.out_valid), 0);

        repeat (3) cyc();
        check("qa_drained", 32'(qa.size()), 0);
        check("qb_drained", 32'(qb.size()), 0);
        check("qc_drained", 32'(qc.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_dot_acc.md
Name: mul_dot_acc

Overview:
- Downstream consumer of the combinational 4x4 unsigned multiplier. It accepts the multiplier's 8-bit products one per handshake and sums N_TERMS of them into a dot-product result.
- Presents the finished sum to the next stage with a valid/ready handshake.
- Provides the first sequential stage after the multiplier datapath. Product generation stays outside this block.

Parameters:
- N_TERMS, 4, number of products summed per dot product; legal range 1..16.
- ACC_W, 12, accumulator/result width; the no-wrap condition is ACC_W >= 8 + ceil(log2(N_TERMS)).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new dot product when IDLE
- clear  input  1  synchronous abort to IDLE; accumulator cleared
- in_valid  input  1  in_prod is valid this cycle
- in_prod  input  8  unsigned product from the 4x4 multiplier
- in_ready  output  1  block accepts in_prod this cycle
- out_valid  output  1  out_sum holds a completed result
- out_sum  output  ACC_W  accumulated sum
- out_ready  input  1  downstream accepts out_sum
- out_ovf  output  1  sticky: accumulator wrapped during this dot product
- busy  output  1  high in ACC or DONE

Behaviour:
- Reset: one clock; reset is synchronous and active-high, sampled on rising clk. After rst: state IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- States and transitions:
  - IDLE: start=1 -> ACC next cycle, with acc=0, cnt=0, out_ovf=0.
  - ACC: in_ready=1. A handshake (in_valid & in_ready) adds in_prod, zero-extended, to acc (acc <= acc + in_prod, modulo 2^ACC_W), increments cnt and sets out_ovf if the add carries out.
  - ACC: when the handshake occurs with cnt==N_TERMS-1 -> DONE; no further input is accepted that cycle onward.
  - DONE: out_valid=1, in_ready=0, out_sum=acc held stable. out_valid & out_ready -> IDLE; out_sum keeps its last value, out_valid drops next cycle.
- Outputs are registered or decoded from state only; there is no combinational path from in_* or out_ready to any output.
- Latency: out_valid rises the cycle after the N_TERMS-th input handshake. Minimum dot product = 1 (start) + N_TERMS + 1 cycles.
- Input gaps: in_valid=0 in ACC leaves acc and cnt unchanged; any number of idle cycles is allowed.
- Backpressure: in DONE with out_ready=0, out_valid and out_sum hold indefinitely.
- start while busy is ignored: no restart, no effect on acc.
- start in the same cycle DONE completes its handshake is ignored; the new start must arrive in IDLE.
- clear has priority over everything except rst. In any state -> IDLE next cycle with acc=0, cnt=0, out_valid=0, out_ovf=0. clear and start in the same cycle: clear wins, stay IDLE.
- rst mid-operation: same as clear; the partial sum is discarded with no out_valid pulse.
- cnt width: ceil(log2(N_TERMS+1)) bits. N_TERMS=1 is legal: one input handshake goes directly to DONE.
- Maximum sum is N_TERMS*225; the defaults give 900 < 4096, so no wrap.

Decomposition:
- Shared package mul_pkg holds:
  - PROD_W=8 (multiplier output width).
  - State encoding typedef: IDLE=2'd0, ACC=2'd1, DONE=2'd2 (2'd3 unreachable; decodes to IDLE).
  - Helper function clog2 for cnt sizing.
- One sub-module is natural: mul_dot_acc_ctrl (FSM + term counter) driving a flat accumulator datapath in the parent. Inlining is acceptable if total RTL stays under 200 lines.

Test Plan:
- Reset, then start, then four products 225,225,225,225 with continuous in_valid -> out_valid on the cycle after the 4th handshake; out_sum=900, out_ovf=0, busy=1 until out_ready.
- Products 1,2,3,4 with two idle in_valid=0 cycles between each -> out_sum=10; cnt and acc unchanged during gaps; in_ready stays 1 throughout ACC.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_sum constant; in_ready=0 and extra in_valid pulses are ignored. out_ready=1 -> IDLE, out_valid=0 next cycle.
- start pulsed during ACC after 2 terms (6,7), then terms 8,9 -> out_sum=30; no restart occurs.
- clear (or rst) after 2 terms, then a fresh start with 10,10,10,10 -> no out_valid for the aborted run; the new out_sum=40.
- Build with ACC_W=9, N_TERMS=4, inputs 225x4 -> out_sum=900 mod 512=388, out_ovf=1. Build with N_TERMS=1, input 200 -> out_sum=200 one cycle after the handshake.
